// File: rtl/tick_gen_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tick_gen_pkg : shared types, default widths and config check for the tick
//                generator. Revision: 1.0
// ---------------------------------------------------------------------------
package tick_gen_pkg;

    localparam int DEF_NUM_CH = 2;
    localparam int DEF_FREQ_W = 32;
    localparam int DEF_CNT_W  = 16;
    // Widest frequency value cfg_valid() can judge.
    localparam int MAX_FREQ_W = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        ERR  = 2'd2
    } tick_state_e;

    // The doubled rate gets one spare bit, so the compare never overflows.
    function automatic logic cfg_valid(input logic [MAX_FREQ_W-1:0] rate_v,
                                       input logic [MAX_FREQ_W-1:0] sys_v);
        logic [MAX_FREQ_W:0] dbl;
        dbl = {rate_v, 1'b0};
        return (rate_v != '0) && (dbl <= {1'b0, sys_v});
    endfunction

endpackage
`default_nettype wire

// File: rtl/tick_gen_ch.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tick_gen_ch : one fractional-accumulator tick channel with its own FSM,
//               counter and error state. Option: TICKGEN_CNT_SAT_EN.
// Revision: 1.0
// ---------------------------------------------------------------------------
module tick_gen_ch
    import tick_gen_pkg::*;
#(
    parameter int FREQ_W = DEF_FREQ_W,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [FREQ_W-1:0] sys_freq,
    input  logic              en,
    input  logic              load,
    input  logic [FREQ_W-1:0] rate,
    output logic              tick,
    output logic [CNT_W-1:0]  tick_cnt,
`ifdef TICKGEN_CNT_SAT_EN
    output logic              sat,
`endif
    output logic              err,
    output logic              busy
);

    tick_state_e       state_q, state_d;
    logic              en_prev_q, en_prev_d;
    logic [FREQ_W-1:0] rate_q, rate_d;
    logic [FREQ_W-1:0] sys_q, sys_d;
    logic [FREQ_W:0]   acc_q, acc_d;
    logic              tick_q, tick_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
`ifdef TICKGEN_CNT_SAT_EN
    logic              sat_q, sat_d;
`endif

    logic              w_cap;
    logic              w_valid;
    logic [FREQ_W:0]   w_sum;
    logic              w_hit;

    // A capture uses this cycle's inputs, so the state decision sees them too.
    assign w_cap   = load | (en & ~en_prev_q);
    assign rate_d  = w_cap ? rate     : rate_q;
    assign sys_d   = w_cap ? sys_freq : sys_q;
    assign w_valid = cfg_valid(MAX_FREQ_W'(rate_d), MAX_FREQ_W'(sys_d));
    assign w_sum   = acc_q + {1'b0, rate_q};
    assign w_hit   = (w_sum >= {1'b0, sys_q});
    assign en_prev_d = en;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        tick_d  = 1'b0;
        cnt_d   = cnt_q;
`ifdef TICKGEN_CNT_SAT_EN
        sat_d   = sat_q;
`endif
        if (!en) begin
            state_d = IDLE;
            acc_d   = '0;
            if (load) begin
                cnt_d = '0;
`ifdef TICKGEN_CNT_SAT_EN
                sat_d = 1'b0;
`endif
            end
        end else if (load || state_q == IDLE) begin
            // Entry from IDLE keeps the count; a load restarts it.
            state_d = w_valid ? RUN : ERR;
            acc_d   = '0;
            if (load) begin
                cnt_d = '0;
`ifdef TICKGEN_CNT_SAT_EN
                sat_d = 1'b0;
`endif
            end
        end else begin
            case (state_q)
                RUN: begin
                    if (w_hit) begin
                        acc_d  = w_sum - {1'b0, sys_q};
                        tick_d = 1'b1;
`ifdef TICKGEN_CNT_SAT_EN
                        if (&cnt_q) begin
                            sat_d = 1'b1;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
`else
                        cnt_d  = cnt_q + CNT_W'(1);
`endif
                    end else begin
                        acc_d = w_sum;
                    end
                end
                ERR: begin
                    acc_d = '0;
                end
                default: begin
                    state_d = IDLE;
                    acc_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            en_prev_q <= 1'b0;
            rate_q    <= '0;
            sys_q     <= '0;
            acc_q     <= '0;
            tick_q    <= 1'b0;
            cnt_q     <= '0;
`ifdef TICKGEN_CNT_SAT_EN
            sat_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            en_prev_q <= en_prev_d;
            rate_q    <= rate_d;
            sys_q     <= sys_d;
            acc_q     <= acc_d;
            tick_q    <= tick_d;
            cnt_q     <= cnt_d;
`ifdef TICKGEN_CNT_SAT_EN
            sat_q     <= sat_d;
`endif
        end
    end

    assign tick     = tick_q;
    assign tick_cnt = cnt_q;
    assign err      = (state_q == ERR);
    assign busy     = (state_q == RUN);
`ifdef TICKGEN_CNT_SAT_EN
    assign sat      = sat_q;
`endif

endmodule
`default_nettype wire

// File: rtl/multi_tick_gen.sv
`default_nettype none
// ---------------------------------------------------------------------------
// multi_tick_gen : NUM_CH independent fractional tick generators sharing one
//                  clock. Option: TICKGEN_CNT_SAT_EN. Revision: 1.0
// ---------------------------------------------------------------------------
module multi_tick_gen
    import tick_gen_pkg::*;
#(
    parameter int NUM_CH = DEF_NUM_CH,
    parameter int FREQ_W = DEF_FREQ_W,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [FREQ_W-1:0]        sys_freq,
    input  logic [NUM_CH-1:0]        en,
    input  logic [NUM_CH-1:0]        load,
    input  logic [NUM_CH*FREQ_W-1:0] rate,
    output logic [NUM_CH-1:0]        tick,
    output logic [NUM_CH*CNT_W-1:0]  tick_cnt,
`ifdef TICKGEN_CNT_SAT_EN
    output logic [NUM_CH-1:0]        sat,
`endif
    output logic [NUM_CH-1:0]        err,
    output logic [NUM_CH-1:0]        busy
);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        tick_gen_ch #(
            .FREQ_W (FREQ_W),
            .CNT_W  (CNT_W)
        ) u_ch (
            .clk      (clk),
            .rst_n    (rst_n),
            .sys_freq (sys_freq),
            .en       (en[i]),
            .load     (load[i]),
            .rate     (rate[i*FREQ_W +: FREQ_W]),
            .tick     (tick[i]),
            .tick_cnt (tick_cnt[i*CNT_W +: CNT_W]),
`ifdef TICKGEN_CNT_SAT_EN
            .sat      (sat[i]),
`endif
            .err      (err[i]),
            .busy     (busy[i])
        );
    end

endmodule
`default_nettype wire

// File: tb/tb_multi_tick_gen.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_multi_tick_gen : scoreboard bench; a rate/period reference model predicts
//                     every cycle's outputs. Revision: 1.0
// ---------------------------------------------------------------------------
module tb_multi_tick_gen;

    localparam int NUM_CH = 2;
    localparam int FREQ_W = 32;
    localparam int CNT_W  = 4;

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic [FREQ_W-1:0]        sys_freq;
    logic [NUM_CH-1:0]        en, load;
    logic [NUM_CH*FREQ_W-1:0] rate;
    logic [NUM_CH-1:0]        tick, err, busy;
    logic [NUM_CH*CNT_W-1:0]  tick_cnt;
`ifdef TICKGEN_CNT_SAT_EN
    logic [NUM_CH-1:0]        sat;
`endif

    always #5 clk = ~clk;

    multi_tick_gen #(.NUM_CH(NUM_CH), .FREQ_W(FREQ_W), .CNT_W(CNT_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .sys_freq (sys_freq),
        .en       (en),
        .load     (load),
        .rate     (rate),
        .tick     (tick),
        .tick_cnt (tick_cnt),
`ifdef TICKGEN_CNT_SAT_EN
        .sat      (sat),
`endif
        .err      (err),
        .busy     (busy)
    );

    typedef struct packed {
        logic [NUM_CH-1:0]       tick;
        logic [NUM_CH*CNT_W-1:0] cnt;
        logic [NUM_CH-1:0]       err;
        logic [NUM_CH-1:0]       busy;
        logic [NUM_CH-1:0]       sat;
    } snap_t;

    snap_t exp_q[$];
    int    tests = 0;
    int    fails = 0;

    // Stimulus for the next cycle, applied by step() at the falling edge.
    logic [NUM_CH-1:0]        n_en = '0, n_load = '0;
    logic [NUM_CH*FREQ_W-1:0] n_rate = '0;
    logic [FREQ_W-1:0]        n_sys = '0;

    // Reference model: ticks are counted as floor(n*rate/sys) over n run edges.
    bit              m_run[NUM_CH], m_err[NUM_CH], m_tick[NUM_CH];
    bit              m_sat[NUM_CH], m_prev_en[NUM_CH];
    longint unsigned m_rate[NUM_CH], m_sys[NUM_CH], m_n[NUM_CH];
    int              m_cnt[NUM_CH];

    function automatic bit tick_at(int ch, longint unsigned n);
        return (n * m_rate[ch] / m_sys[ch]) != ((n - 1) * m_rate[ch] / m_sys[ch]);
    endfunction

    function automatic bit would_tick(int ch);
        return m_run[ch] && tick_at(ch, m_n[ch] + 1);
    endfunction

    task automatic model_reset();
        for (int c = 0; c < NUM_CH; c++) begin
            m_run[c] = 0; m_err[c] = 0; m_tick[c] = 0; m_sat[c] = 0;
            m_prev_en[c] = 0; m_rate[c] = 0; m_sys[c] = 0; m_n[c] = 0; m_cnt[c] = 0;
        end
    endtask

    task automatic model_step();
        for (int c = 0; c < NUM_CH; c++) begin
            bit e, l, ok;
            e = n_en[c];
            l = n_load[c];
            if (l || (e && !m_prev_en[c])) begin
                m_rate[c] = longint'(n_rate[c*FREQ_W +: FREQ_W]);
                m_sys[c]  = longint'(n_sys);
            end
            ok = (m_rate[c] != 0) && (2 * m_rate[c] <= m_sys[c]);
            m_tick[c] = 0;
            if (l) begin
                m_cnt[c] = 0;
                m_sat[c] = 0;
            end
            if (!e) begin
                m_run[c] = 0; m_err[c] = 0; m_n[c] = 0;
            end else if (l || (!m_run[c] && !m_err[c])) begin
                m_run[c] = ok; m_err[c] = !ok; m_n[c] = 0;
            end else if (m_run[c]) begin
                m_n[c]++;
                if (tick_at(c, m_n[c])) begin
                    m_tick[c] = 1;
`ifdef TICKGEN_CNT_SAT_EN
                    if (m_cnt[c] == (1 << CNT_W) - 1) m_sat[c] = 1;
                    else m_cnt[c]++;
`else
                    m_cnt[c] = (m_cnt[c] + 1) % (1 << CNT_W);
`endif
                end
            end
            m_prev_en[c] = e;
        end
    endtask

    function automatic snap_t model_snap();
        snap_t s;
        s = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            s.tick[c] = m_tick[c];
            s.cnt[c*CNT_W +: CNT_W] = CNT_W'(m_cnt[c]);
            s.err[c]  = m_err[c];
            s.busy[c] = m_run[c];
            s.sat[c]  = m_sat[c];
        end
        return s;
    endfunction

    function automatic snap_t dut_snap();
        snap_t s;
        s = '0;
        s.tick = tick;
        s.cnt  = tick_cnt;
        s.err  = err;
        s.busy = busy;
`ifdef TICKGEN_CNT_SAT_EN
        s.sat  = sat;
`endif
        return s;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, want, $time);
        end
    endtask

    task automatic step();
        @(negedge clk);
        rst_n    = 1'b1;
        en       = n_en;
        load     = n_load;
        rate     = n_rate;
        sys_freq = n_sys;
        model_step();
        exp_q.push_back(model_snap());
        n_load = '0;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Drops rst_n between edges and checks the outputs clear straight away.
    task automatic do_reset(input int cycles);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("reset_tick", 32'(tick), 0);
        check("reset_cnt", 32'(tick_cnt), 0);
        check("reset_busy_err", 32'({busy, err}), 0);
        model_reset();
        exp_q.push_back(model_snap());
        for (int i = 1; i < cycles; i++) begin
            @(negedge clk);
            exp_q.push_back(model_snap());
        end
    endtask

    task automatic set_rate(input int ch, input int r);
        n_rate[ch*FREQ_W +: FREQ_W] = FREQ_W'(r);
    endtask

    // Sample point: just after the edge that executes the last queued step.
    task automatic after_edge();
        @(posedge clk);
        #2;
    endtask

    always @(posedge clk) begin : monitor
        snap_t e, g;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = dut_snap();
            tests++;
            if (g !== e) begin
                fails++;
                $display("FAIL outputs t=%0t: got tick=%b cnt=%h err=%b busy=%b sat=%b, expected tick=%b cnt=%h err=%b busy=%b sat=%b",
                         $time, g.tick, g.cnt, g.err, g.busy, g.sat,
                         e.tick, e.cnt, e.err, e.busy, e.sat);
            end
        end
    end

    initial begin
        bit found;
        rst_n = 1'b0; en = '0; load = '0; rate = '0; sys_freq = '0;
        model_reset();
        do_reset(5);

        // Fractional rate: ticks at run edges 11 and 21.
        n_sys = 100000;
        set_rate(0, 9600);
        n_en = 2'b01;
        steps(22);
        after_edge();
        check("ch0_second_tick", 32'(tick[0]), 1);
        check("ch0_cnt_two", 32'(tick_cnt[0 +: CNT_W]), 2);

        // Integer divide on channel 1 while channel 0 keeps running.
        set_rate(1, 50000);
        n_en = 2'b11;
        steps(21);
        after_edge();
        check("ch1_cnt_ten", 32'(tick_cnt[CNT_W +: CNT_W]), 10);

        // Invalid configurations, then recovery by load.
        n_en[0] = 0; step();
        set_rate(0, 0); n_en[0] = 1; steps(6);
        after_edge();
        check("ch0_err_zero_rate", 32'({err[0], busy[0]}), 2);
        n_en[0] = 0; step();
        set_rate(0, 60000); n_en[0] = 1; steps(4);
        after_edge();
        check("ch0_err_too_fast", 32'(err[0]), 1);
        set_rate(0, 9600); n_load[0] = 1; steps(3);
        after_edge();
        check("ch0_recovered", 32'({err[0], busy[0]}), 1);

        // Load landing on the cycle a tick would fire.
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (would_tick(0)) begin
                n_load[0] = 1;
                found = 1;
            end
            step();
        end
        check("load_slot_found", 32'(found), 1);
        after_edge();
        check("load_drops_tick", 32'(tick[0]), 0);
        check("load_clears_cnt", 32'(tick_cnt[0 +: CNT_W]), 0);
        steps(14);

        // Counter wrap (or saturation) at rate = sys/2.
        n_en = 2'b00; step();
        set_rate(0, 50000); n_load[0] = 1; step();
        n_en[0] = 1;
        steps(33);
        after_edge();
`ifdef TICKGEN_CNT_SAT_EN
        check("cnt_saturated", 32'(tick_cnt[0 +: CNT_W]), 15);
        check("sat_set", 32'(sat[0]), 1);
`else
        check("cnt_wrapped", 32'(tick_cnt[0 +: CNT_W]), 0);
`endif

        // Asynchronous reset mid-run, release with en held high.
        set_rate(0, 9600);
        n_load[0] = 1;
        steps(7);
        do_reset(2);
        steps(25);

        // Randomised traffic with small sys_freq so ticks and wraps are frequent.
        n_sys = 97;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0) n_sys = FREQ_W'($urandom_range(2, 300));
            for (int c = 0; c < NUM_CH; c++) begin
                if ($urandom_range(0, 39) == 0) n_en[c] = ~n_en[c];
                if ($urandom_range(0, 29) == 0) set_rate(c, $urandom_range(0, int'(n_sys) * 6 / 10));
                if ($urandom_range(0, 49) == 0) n_load[c] = 1;
            end
            if ($urandom_range(0, 1499) == 0) do_reset(2);
            else step();
        end

        repeat (3) @(posedge clk);
        #2;
        check("scoreboard_drained", 32'(exp_q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
